// File: rtl/piano_key_event_detector_if.sv
// Key-input / note-event bundle between the key source and the event detector.
interface piano_key_event_detector_if #(
  parameter int unsigned NUM_KEYS = 7
);

  localparam int unsigned ID_W = 3;

  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] keys_stable;
  logic                new_note_valid_pulse;
  logic [ID_W-1:0]     new_note_id;
  logic [ID_W-1:0]     held_note_id;
  logic                note_active;

  // Key source side: drives raw levels, observes note events.
  modport master (
    output keys_raw,
    input  keys_stable,
    input  new_note_valid_pulse,
    input  new_note_id,
    input  held_note_id,
    input  note_active
  );

  // Detector side: samples raw levels, produces note events.
  modport slave (
    input  keys_raw,
    output keys_stable,
    output new_note_valid_pulse,
    output new_note_id,
    output held_note_id,
    output note_active
  );

endinterface

// File: rtl/piano_key_event_detector.sv
// Piano key front end: per-key synchroniser and debouncer, press-edge
// detection, lowest-index priority encoding of new presses and held keys.
module piano_key_event_detector #(
  parameter int unsigned NUM_KEYS        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  piano_key_event_detector_if.slave     key_if
);

  localparam int unsigned ID_W = 3;
  // Terminal count: stable flips on the DEBOUNCE_CYCLES-th differing edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [CNT_W-1:0]    r_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_stable;
  logic [NUM_KEYS-1:0] r_prev;
  logic                r_pulse;
  logic [ID_W-1:0]     r_new_id;
  logic [ID_W-1:0]     r_held_id;
  logic                r_active;

  logic [NUM_KEYS-1:0] w_rise;
  logic [ID_W-1:0]     w_rise_id;
  logic [ID_W-1:0]     w_held_id;

  // Two-flop synchroniser for the asynchronous key levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_if.keys_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: any agreement with the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_stable[k] <= r_sync2[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Keys that became stable-pressed since the previous cycle.
  always_comb begin
    w_rise = r_stable & ~r_prev;
  end

  // Lowest-index rising key wins; other simultaneous rises are dropped.
  always_comb begin
    w_rise_id = '0;
    for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
      if (w_rise[k]) begin
        w_rise_id = ID_W'(k + 1);
      end
    end
  end

  // Lowest-index held key, 0 when nothing is held.
  always_comb begin
    w_held_id = '0;
    for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
      if (r_stable[k]) begin
        w_held_id = ID_W'(k + 1);
      end
    end
  end

  // Registered note event plus held-note status, all updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= '0;
      r_pulse   <= 1'b0;
      r_new_id  <= '0;
      r_held_id <= '0;
      r_active  <= 1'b0;
    end else begin
      r_prev    <= r_stable;
      r_held_id <= w_held_id;
      r_active  <= |r_stable;
      if (|w_rise) begin
        r_pulse  <= 1'b1;
        r_new_id <= w_rise_id;
      end else begin
        r_pulse  <= 1'b0;
      end
    end
  end

  assign key_if.keys_stable          = r_stable;
  assign key_if.new_note_valid_pulse = r_pulse;
  assign key_if.new_note_id          = r_new_id;
  assign key_if.held_note_id         = r_held_id;
  assign key_if.note_active          = r_active;

endmodule

// File: tb/tb_piano_key_event_detector.sv
// Self-checking bench for the piano key event detector (short debounce).
module tb_piano_key_event_detector;

  localparam int unsigned NUM_KEYS = 7;
  localparam int unsigned DEB      = 4;
  localparam int unsigned CNT_W    = 3;

  typedef struct {
    logic [6:0] raw;
    int         cycles;
    int         pulses;
    logic [2:0] new_id;
    logic [2:0] held;
    logic       active;
    logic [6:0] stable;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  vec_t sb_q[$];

  piano_key_event_detector_if #(.NUM_KEYS(NUM_KEYS)) key_if ();

  piano_key_event_detector #(
    .NUM_KEYS       (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_if(key_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stable"}, 32'(key_if.keys_stable), 32'd0);
    chk({tag, "_pulse"},  32'(key_if.new_note_valid_pulse), 32'd0);
    chk({tag, "_new_id"}, 32'(key_if.new_note_id), 32'd0);
    chk({tag, "_held"},   32'(key_if.held_note_id), 32'd0);
    chk({tag, "_active"}, 32'(key_if.note_active), 32'd0);
  endtask

  function automatic vec_t mk(input logic [6:0] raw, input int cyc, input int pul,
                              input logic [2:0] nid, input logic [2:0] hid,
                              input logic act, input logic [6:0] stb);
    vec_t v;
    v.raw = raw; v.cycles = cyc; v.pulses = pul; v.new_id = nid;
    v.held = hid; v.active = act; v.stable = stb;
    return v;
  endfunction

  // Drive one table row, count pulses over its window, then score it.
  task automatic run_row(input int idx, input vec_t v);
    int   pulses;
    int   run;
    int   max_run;
    vec_t e;
    key_if.keys_raw = v.raw;
    sb_q.push_back(v);
    pulses = 0; run = 0; max_run = 0;
    for (int c = 0; c < v.cycles; c++) begin
      tick();
      if (key_if.new_note_valid_pulse) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    e = sb_q.pop_front();
    chk($sformatf("row%0d_pulses", idx), 32'(pulses), 32'(e.pulses));
    chk($sformatf("row%0d_pulse_width", idx), 32'(max_run), (e.pulses > 0) ? 32'd1 : 32'd0);
    chk($sformatf("row%0d_new_id", idx), 32'(key_if.new_note_id), 32'(e.new_id));
    chk($sformatf("row%0d_held", idx), 32'(key_if.held_note_id), 32'(e.held));
    chk($sformatf("row%0d_active", idx), 32'(key_if.note_active), 32'(e.active));
    chk($sformatf("row%0d_stable", idx), 32'(key_if.keys_stable), 32'(e.stable));
  endtask

  // Edge-exact check of a press of raw keys 'raw' seen from edge 1 onwards.
  task automatic press_timing(input string tag, input logic [6:0] raw, input logic [2:0] id);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("%s_e%0d_stable", tag, e), 32'(key_if.keys_stable),
          (e >= int'(DEB) + 2) ? 32'(raw) : 32'd0);
      chk($sformatf("%s_e%0d_pulse", tag, e), 32'(key_if.new_note_valid_pulse),
          (e == int'(DEB) + 3) ? 32'd1 : 32'd0);
      if (e == int'(DEB) + 3) begin
        chk({tag, "_new_id"}, 32'(key_if.new_note_id), 32'(id));
        chk({tag, "_held"},   32'(key_if.held_note_id), 32'(id));
        chk({tag, "_active"}, 32'(key_if.note_active), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with every key pressed: outputs must stay cleared.
    rst_n = 1'b0;
    key_if.keys_raw = 7'h7F;
    repeat (3) tick();
    chk_all_zero("reset");
    key_if.keys_raw = 7'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all_zero("post_reset");

    // Single press of key 2 with edge-exact latency.
    key_if.keys_raw = 7'b0000100;
    press_timing("single", 7'b0000100, 3'd3);
    tick();
    chk("single_pulse_drop", 32'(key_if.new_note_valid_pulse), 32'd0);

    //            raw    cyc pul nid   held  act  stable
    vecs.push_back(mk(7'h00, 10, 0, 3'd3, 3'd0, 1'b0, 7'h00)); // release key 2
    vecs.push_back(mk(7'h01,  3, 0, 3'd3, 3'd0, 1'b0, 7'h00)); // 3-cycle glitch
    vecs.push_back(mk(7'h00, 10, 0, 3'd3, 3'd0, 1'b0, 7'h00)); // glitch rejected
    vecs.push_back(mk(7'h01, 10, 1, 3'd1, 3'd1, 1'b1, 7'h01)); // real press key 0
    vecs.push_back(mk(7'h00, 10, 0, 3'd1, 3'd0, 1'b0, 7'h00));
    vecs.push_back(mk(7'h42, 10, 1, 3'd2, 3'd2, 1'b1, 7'h42)); // keys 6+1 together
    vecs.push_back(mk(7'h00, 10, 0, 3'd2, 3'd0, 1'b0, 7'h00));
    vecs.push_back(mk(7'h10, 10, 1, 3'd5, 3'd5, 1'b1, 7'h10)); // hold key 4
    vecs.push_back(mk(7'h11, 10, 1, 3'd1, 3'd1, 1'b1, 7'h11)); // add key 0
    vecs.push_back(mk(7'h10, 10, 0, 3'd1, 3'd5, 1'b1, 7'h10)); // release key 0
    vecs.push_back(mk(7'h00, 10, 0, 3'd1, 3'd0, 1'b0, 7'h00)); // release all
    vecs.push_back(mk(7'h10, 10, 1, 3'd5, 3'd5, 1'b1, 7'h10)); // re-press key 4
    vecs.push_back(mk(7'h50, 10, 1, 3'd7, 3'd5, 1'b1, 7'h50)); // higher key over held
    vecs.push_back(mk(7'h00, 10, 0, 3'd7, 3'd0, 1'b0, 7'h00));
    vecs.push_back(mk(7'h08, 10, 1, 3'd4, 3'd4, 1'b1, 7'h08)); // hold key 3
    for (int i = 0; i < vecs.size(); i++) begin
      run_row(i, vecs[i]);
    end

    // Reset mid-hold: key 3 stays pressed through a 2-cycle reset.
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst_async");
    repeat (2) tick();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    press_timing("rerelease", 7'b0001000, 3'd4);

    key_if.keys_raw = 7'h00;
    repeat (10) tick();
    chk("final_active", 32'(key_if.note_active), 32'd0);
    chk("final_new_id", 32'(key_if.new_note_id), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
